// File: rtl/ks_wide_add_ctrl.sv
// ---------------------------------------------------------------------------
// ks_wide_add_ctrl
//
// Sequences a wide (BW*WORDS bit) addition through one shared BW-bit
// Kogge-Stone adder, one slice per pass, least significant slice first.
// The carry out of each slice is registered and fed back as the carry in of
// the next slice, so the adder never sees a carry that has not been captured.
//
// Parameters
//   BW      : adder slice width in bits
//   WORDS   : number of slices per operand
//   ADD_LAT : cycles from operands presented to adder result valid
//             (0 = combinational adder)
//
// Ports
//   clk      : sole clock, rising edge
//   resetn   : synchronous active-low reset
//   start    : request a wide add (accepted only while busy is low)
//   op_a     : operand A, BW*WORDS bits
//   op_b     : operand B, BW*WORDS bits
//   cin      : carry into the least significant slice
//   busy     : high while an add is in progress
//   done     : one-cycle pulse, result and cout valid
//   result   : wide sum, held until the next accepted start
//   cout     : carry out of the most significant slice
//   add_a    : slice operand A driven to the shared adder
//   add_b    : slice operand B driven to the shared adder
//   add_cin  : slice carry-in driven to the shared adder
//   add_sum  : slice sum returned by the adder
//   add_cout : slice carry-out returned by the adder
// ---------------------------------------------------------------------------
module ks_wide_add_ctrl #(
  parameter int BW      = 32,
  parameter int WORDS   = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [BW*WORDS-1:0] op_a,
  input  logic [BW*WORDS-1:0] op_b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [BW*WORDS-1:0] result,
  output logic                cout,
  output logic [BW-1:0]       add_a,
  output logic [BW-1:0]       add_b,
  output logic                add_cin,
  input  logic [BW-1:0]       add_sum,
  input  logic                add_cout
);

  localparam int W     = BW * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LAT_W = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(ADD_LAT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [IDX_W-1:0] idx;
  logic [LAT_W-1:0] lat_cnt;
  logic             carry_q;

  logic [IDX_W-1:0] idx_next;
  logic [BW-1:0]    next_a;
  logic [BW-1:0]    next_b;
  logic             capture;

  // The carry register is the adder's carry-in: it holds the latched cin
  // for slice 0 and the captured carry of slice i-1 afterwards, and is
  // cleared whenever the adder is not in use.
  assign add_cin = carry_q;

  // idx_next wraps on the last slice, but it is only consumed when another
  // slice follows.
  assign idx_next = idx + 1'b1;

  // The adder result is taken on the edge ending ISSUE for a combinational
  // adder, otherwise on the edge ending the last WAIT cycle.
  assign capture = ((state == ISSUE) && (ADD_LAT == 0)) ||
                   ((state == WAIT) && (lat_cnt == LAT_MAX));

  // Operand slices for the next pass, taken from the latched operands so
  // that the live op_* inputs cannot disturb an add in progress.
  always_comb begin
    next_a = '0;
    next_b = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_next == IDX_W'(w)) begin
        next_a = a_q[w*BW +: BW];
        next_b = b_q[w*BW +: BW];
      end
    end
  end

  // Control FSM. Adder operands are registered and loaded one edge ahead
  // of each ISSUE cycle, so they stay stable until the capture edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      lat_cnt <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            idx     <= '0;
            lat_cnt <= '0;
            add_a   <= op_a[BW-1:0];
            add_b   <= op_b[BW-1:0];
            carry_q <= cin;
            // Clear so a new sum is never mixed with slices of the old one.
            result  <= '0;
            cout    <= 1'b0;
            busy    <= 1'b1;
            state   <= ISSUE;
          end else begin
            add_a   <= '0;
            add_b   <= '0;
            carry_q <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end

        ISSUE, WAIT: begin
          if (capture) begin
            for (int w = 0; w < WORDS; w++) begin
              if (idx == IDX_W'(w)) begin
                result[w*BW +: BW] <= add_sum;
              end
            end
            lat_cnt <= '0;
            if (idx == LAST_IDX) begin
              cout    <= add_cout;
              done    <= 1'b1;
              busy    <= 1'b0;
              add_a   <= '0;
              add_b   <= '0;
              carry_q <= 1'b0;
              state   <= DONE;
            end else begin
              idx     <= idx_next;
              add_a   <= next_a;
              add_b   <= next_b;
              carry_q <= add_cout;
              state   <= ISSUE;
            end
          end else if (state == ISSUE) begin
            // Counter runs 1..ADD_LAT across the WAIT cycles.
            lat_cnt <= LAT_W'(1);
            state   <= WAIT;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ks_wide_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ks_wide_add_ctrl
//
// Three controllers (ADD_LAT = 1, 0 and 3) each driving their own delayed
// adder model. Expected sums come from plain wide arithmetic on the whole
// operands, pushed into a scoreboard at issue time and popped by a monitor
// whenever any controller pulses done.
// ---------------------------------------------------------------------------
module tb_ks_wide_add_ctrl;

  localparam int BW       = 32;
  localparam int WORDS    = 4;
  localparam int W        = BW * WORDS;
  localparam int WX       = W + 1;
  localparam int NINST    = 3;
  localparam int RAND_OPS = 1000;

  typedef struct {
    int          inst;
    logic [W:0]  val;
    int          due;
  } exp_t;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: during the cycle following edge n it reads n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NINST-1:0]         resetn_s;
  logic [NINST-1:0]         start_s;
  logic [NINST-1:0]         cin_s;
  logic [NINST-1:0]         busy_s;
  logic [NINST-1:0]         done_s;
  logic [NINST-1:0]         cout_s;
  logic [NINST-1:0]         add_cin_s;
  logic [NINST-1:0]         add_cout_s;
  logic [NINST-1:0][W-1:0]  op_a_s;
  logic [NINST-1:0][W-1:0]  op_b_s;
  logic [NINST-1:0][W-1:0]  result_s;
  logic [NINST-1:0][BW-1:0] add_a_s;
  logic [NINST-1:0][BW-1:0] add_b_s;
  logic [NINST-1:0][BW-1:0] add_sum_s;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  for (genvar g = 0; g < NINST; g++) begin : g_inst
    localparam int L = lat_of(g);
    logic [BW:0] full_sum;

    assign full_sum = {1'b0, add_a_s[g]} + {1'b0, add_b_s[g]} + {{BW{1'b0}}, add_cin_s[g]};

    // Adder model: result appears L cycles after operands are presented.
    if (L == 0) begin : g_comb
      assign {add_cout_s[g], add_sum_s[g]} = full_sum;
    end else begin : g_pipe
      logic [BW:0] pipe [L];
      always @(posedge clk) begin
        pipe[0] <= full_sum;
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
      end
      assign {add_cout_s[g], add_sum_s[g]} = pipe[L-1];
    end

    ks_wide_add_ctrl #(
      .BW     (BW),
      .WORDS  (WORDS),
      .ADD_LAT(L)
    ) u_dut (
      .clk     (clk),
      .resetn  (resetn_s[g]),
      .start   (start_s[g]),
      .op_a    (op_a_s[g]),
      .op_b    (op_b_s[g]),
      .cin     (cin_s[g]),
      .busy    (busy_s[g]),
      .done    (done_s[g]),
      .result  (result_s[g]),
      .cout    (cout_s[g]),
      .add_a   (add_a_s[g]),
      .add_b   (add_b_s[g]),
      .add_cin (add_cin_s[g]),
      .add_sum (add_sum_s[g]),
      .add_cout(add_cout_s[g])
    );
  end

  task automatic checkOutput(input string name, input logic [W:0] actual, input logic [W:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [W-1:0] randWide();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called on a falling edge; returns on the falling edge of cycle 1.
  task automatic applyStimulus(input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input bit expect_done);
    exp_t e;
    int   acc;
    start_s[g] = 1'b1;
    op_a_s[g]  = a;
    op_b_s[g]  = b;
    cin_s[g]   = c;
    @(negedge clk);
    acc = cyc;
    checkOutput($sformatf("accept_busy_i%0d", g), WX'(busy_s[g]), WX'(1));
    checkOutput($sformatf("issue_add_a_i%0d", g), WX'(add_a_s[g]), WX'(a[BW-1:0]));
    checkOutput($sformatf("issue_add_cin_i%0d", g), WX'(add_cin_s[g]), WX'(c));
    if (expect_done) begin
      e.inst = g;
      e.val  = {1'b0, a} + {1'b0, b} + WX'(c);
      e.due  = acc + WORDS * (lat_of(g) + 1);
      sb.push_back(e);
    end
    // Scramble the live inputs: the add in progress must not see them.
    start_s[g] = 1'b0;
    op_a_s[g]  = randWide();
    op_b_s[g]  = randWide();
    cin_s[g]   = 1'($urandom);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: %0d results pending after %0d cycles, expected 0", sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic randomOp(input int g);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    a = randWide();
    b = randWide();
    c = 1'($urandom);
    case ($urandom_range(0, 3))
      1: b = ~a;
      2: begin
        a = '1;
        b = W'($urandom_range(0, 3));
      end
      default: ;
    endcase
    applyStimulus(g, a, b, c, 1'b1);
    waitIdle(WORDS * (lat_of(g) + 1) + 20);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int g = 0; g < NINST; g++) begin
      if (done_s[g] === 1'b1) begin
        if (sb.size() == 0 || sb[0].inst != g) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: inst %0d got done=1, expected no done", g);
        end else begin
          e = sb.pop_front();
          checkOutput($sformatf("sum_i%0d", g), {cout_s[g], result_s[g]}, e.val);
          checkOutput($sformatf("done_cycle_i%0d", g), WX'(cyc), WX'(e.due));
          checkOutput($sformatf("done_busy_i%0d", g), WX'(busy_s[g]), WX'(0));
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    logic [W-1:0] a;
    logic [W-1:0] b;

    // Reset with start held high: the start must be ignored.
    resetn_s = '0;
    start_s  = '1;
    cin_s    = '1;
    op_a_s   = '1;
    op_b_s   = '1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NINST; g++) begin
      checkOutput($sformatf("rst_busy_i%0d", g), WX'(busy_s[g]), WX'(0));
      checkOutput($sformatf("rst_done_i%0d", g), WX'(done_s[g]), WX'(0));
      checkOutput($sformatf("rst_result_i%0d", g), {cout_s[g], result_s[g]}, WX'(0));
      checkOutput($sformatf("rst_add_a_i%0d", g), WX'(add_a_s[g]), WX'(0));
      checkOutput($sformatf("rst_add_b_i%0d", g), WX'(add_b_s[g]), WX'(0));
      checkOutput($sformatf("rst_add_cin_i%0d", g), WX'(add_cin_s[g]), WX'(0));
    end
    start_s  = '0;
    resetn_s = '1;
    @(negedge clk);
    checkOutput("idle_after_reset", WX'(busy_s[0]), WX'(0));

    // Full carry ripple.
    applyStimulus(0, '1, '0, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("ripple_done_c9", WX'(done_s[0]), WX'(1));
    waitIdle(20);

    // Carry chaining from slice 0 into slice 1, then idle adder outputs.
    a = '0;
    a[31:0] = 32'hFFFF_FFFF;
    b = W'(1);
    applyStimulus(0, a, b, 1'b0, 1'b1);
    waitIdle(20);
    @(negedge clk);
    checkOutput("idle_add_a", WX'(add_a_s[0]), WX'(0));
    checkOutput("idle_add_b", WX'(add_b_s[0]), WX'(0));
    checkOutput("idle_add_cin", WX'(add_cin_s[0]), WX'(0));
    checkOutput("idle_busy", WX'(busy_s[0]), WX'(0));

    // Start while busy is ignored.
    applyStimulus(0, randWide(), randWide(), 1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      checkOutput($sformatf("busy_cycle%0d", k), WX'(busy_s[0]), WX'(1));
      start_s[0] = (k == 3);
      if (k == 3) begin
        op_a_s[0] = randWide();
        op_b_s[0] = randWide();
      end
      @(negedge clk);
    end
    start_s[0] = 1'b0;
    checkOutput("busy_start_done_c9", WX'(done_s[0]), WX'(1));
    waitIdle(20);

    // Back-to-back: second start issued in the DONE cycle.
    applyStimulus(0, randWide(), randWide(), 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("b2b_first_done", WX'(done_s[0]), WX'(1));
    applyStimulus(0, randWide(), randWide(), 1'b1, 1'b1);
    waitIdle(20);

    // Reset in cycle 5 aborts the add with no done pulse.
    applyStimulus(0, randWide() | W'(1), randWide() | W'(1), 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    resetn_s[0] = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", WX'(busy_s[0]), WX'(0));
    checkOutput("abort_done", WX'(done_s[0]), WX'(0));
    checkOutput("abort_result", {cout_s[0], result_s[0]}, WX'(0));
    resetn_s[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("abort_no_done%0d", k), WX'(done_s[0]), WX'(0));
    end

    // Randomised runs on every latency.
    repeat (40) randomOp(0);
    repeat (RAND_OPS) randomOp(1);
    repeat (RAND_OPS) randomOp(2);

    waitIdle(40);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
